// File: rtl/onchip_mem_copy_dma.sv
// onchip_mem_copy_dma: Avalon-MM RAM-to-RAM block copy engine fronting a single-port on-chip RAM.
// Each word takes three cycles (read, latch, write); completion raises sticky done and a maskable irq.
module onchip_mem_copy_dma #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 14
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        csr_address,
   input  logic              csr_chipselect,
   input  logic              csr_write,
   input  logic              csr_read,
   input  logic [31:0]       csr_writedata,
   output logic [31:0]       csr_readdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic              irq
);
   typedef enum logic [1:0] {IDLE, READ, LATCH, WRITE} state_t;
   state_t state;
   logic [ADDR_W-1:0] src, dst, src_ptr, dst_ptr;
   logic [LEN_W-1:0] len, remaining;
   logic ie, done, busy, wr, start;
   logic [31:0] rd_mux;
   logic unused_bits;

   assign busy = state != IDLE;
   assign wr = csr_chipselect & csr_write;
   assign start = wr && csr_address == 2'd3 && csr_writedata[0];
   assign irq = done & ie;
   assign mem_clken = 1'b1;
   assign mem_byteenable = {4{mem_chipselect}};
   assign unused_bits = ^csr_writedata[31:LEN_W];
   assign rd_mux = csr_address == 2'd0 ? 32'(src) :
                   csr_address == 2'd1 ? 32'(dst) :
                   csr_address == 2'd2 ? 32'(len) : {29'd0, ie, done, busy};

   // mem_writedata doubles as the word buffer latched in LATCH
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         src            <= '0;
         dst            <= '0;
         len            <= '0;
         src_ptr        <= '0;
         dst_ptr        <= '0;
         remaining      <= '0;
         ie             <= 1'b0;
         done           <= 1'b0;
         csr_readdata   <= '0;
         mem_address    <= '0;
         mem_chipselect <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
      end else begin
         if (csr_chipselect && csr_read) csr_readdata <= rd_mux;
         if (wr && !busy && csr_address == 2'd0) src <= csr_writedata[ADDR_W-1:0];
         if (wr && !busy && csr_address == 2'd1) dst <= csr_writedata[ADDR_W-1:0];
         if (wr && !busy && csr_address == 2'd2) len <= csr_writedata[LEN_W-1:0];
         if (wr && csr_address == 2'd3) begin
            ie <= csr_writedata[1];
            if (csr_writedata[2]) done <= 1'b0;
         end
         case (state)
            IDLE: if (start) begin
               src_ptr   <= src;
               dst_ptr   <= dst;
               remaining <= len;
               done      <= len == '0;
               if (len != '0) begin
                  state          <= READ;
                  mem_address    <= src;
                  mem_chipselect <= 1'b1;
                  mem_write      <= 1'b0;
               end
            end
            READ: begin
               state          <= LATCH;
               mem_chipselect <= 1'b0;
            end
            LATCH: begin
               state          <= WRITE;
               mem_address    <= dst_ptr;
               mem_chipselect <= 1'b1;
               mem_write      <= 1'b1;
               mem_writedata  <= mem_readdata;
            end
            WRITE: begin
               src_ptr   <= src_ptr + ADDR_W'(1);
               dst_ptr   <= dst_ptr + ADDR_W'(1);
               remaining <= remaining - LEN_W'(1);
               mem_write <= 1'b0;
               if (remaining == LEN_W'(1)) begin
                  state          <= IDLE;
                  done           <= 1'b1;
                  mem_chipselect <= 1'b0;
                  mem_address    <= '0;
               end else begin
                  state       <= READ;
                  mem_address <= src_ptr + ADDR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
